// File: rtl/ctrl_seq_pkg.sv
// Shared constants, state encoding and beat payload for the control-word sequencer.
package ctrl_seq_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned CW_W     = 26;
    localparam int unsigned BEAT_W   = 2;
    localparam int unsigned TMR_W    = 8;
    localparam int unsigned BEAT_LSB = 5;
    localparam int unsigned BEAT_MSB = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEC   = 2'd1,
        ISSUE = 2'd2
    } state_e;

    // Word currently presented to the datapath plus its beat tag.
    typedef struct packed {
        logic [CW_W-1:0]   word;
        logic [BEAT_W-1:0] idx;
        logic              last;
    } beat_t;

    // Index of the final beat; the opcode encodes beat count minus one.
    function automatic logic [BEAT_W-1:0] last_beat(input logic [OP_W-1:0] op);
        return op[BEAT_MSB:BEAT_LSB];
    endfunction

endpackage

// File: rtl/ctrl_seq_tmo.sv
// Stall counter: counts enabled cycles and flags the cycle that brings the count to LIMIT.
module ctrl_seq_tmo
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_c
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TMR_W'(LIMIT))) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_c = en_i && !clr_i && (cnt_q == TMR_W'(LIMIT - 1));

endmodule

// File: rtl/ctrl_seq.sv
// Opcode-to-control-word sequencer: registers the opcode for the external decoder,
// captures its result and issues it as 1-4 tagged beats with flush and stall timeout.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_code,
    input  logic              flush,
    output logic [OP_W-1:0]   dec_op,
    input  logic [CW_W-1:0]   dec_cw,
    output logic              cw_valid,
    input  logic              cw_ready,
    output logic [CW_W-1:0]   cw,
    output logic [BEAT_W-1:0] cw_beat,
    output logic              cw_last,
    output logic              busy,
    output logic              err_tmo
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   dec_op_q, dec_op_d;
    logic [BEAT_W-1:0] lastb_q, lastb_d;
    beat_t             beat_q, beat_d;
    logic              cw_valid_q, cw_valid_d;
    logic              err_tmo_q, err_tmo_d;

    logic accept_c;
    logic tmo_en_c;
    logic tmo_clr_c;
    logic tmo_hit_c;

    assign accept_c  = cw_valid_q && cw_ready;
    assign tmo_en_c  = (state_q == ISSUE) && cw_valid_q && !cw_ready;
    assign tmo_clr_c = (state_q != ISSUE) || flush || accept_c;

    ctrl_seq_tmo #(.LIMIT(TMO_CYC)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (tmo_clr_c),
        .en_i  (tmo_en_c),
        .hit_c (tmo_hit_c)
    );

    // Next-state and datapath-register update; flush outranks accept and timeout.
    always_comb begin
        state_d    = state_q;
        dec_op_d   = dec_op_q;
        lastb_d    = lastb_q;
        beat_d     = beat_q;
        cw_valid_d = cw_valid_q;
        err_tmo_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (op_valid && !flush) begin
                    dec_op_d = op_code;
                    lastb_d  = last_beat(op_code);
                    state_d  = DEC;
                end
            end
            DEC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    beat_d.word = dec_cw;
                    beat_d.idx  = '0;
                    beat_d.last = (lastb_q == '0);
                    cw_valid_d  = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    cw_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (accept_c) begin
                    if (beat_q.last) begin
                        cw_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        beat_d.idx  = beat_q.idx + BEAT_W'(1);
                        beat_d.last = (beat_d.idx == lastb_q);
                    end
                end else if (tmo_hit_c) begin
                    err_tmo_d   = 1'b1;
                    cw_valid_d  = 1'b0;
                    beat_d.idx  = '0;
                    beat_d.last = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cw_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dec_op_q   <= '0;
            lastb_q    <= '0;
            beat_q     <= '0;
            cw_valid_q <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dec_op_q   <= dec_op_d;
            lastb_q    <= lastb_d;
            beat_q     <= beat_d;
            cw_valid_q <= cw_valid_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    // Ready depends only on state, except a same-cycle flush blocks acceptance.
    assign op_ready = (state_q == IDLE) && !flush;
    assign busy     = (state_q != IDLE);
    assign dec_op   = dec_op_q;
    assign cw_valid = cw_valid_q;
    assign cw       = beat_q.word;
    assign cw_beat  = beat_q.idx;
    assign cw_last  = beat_q.last;
    assign err_tmo  = err_tmo_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: directed scenarios plus a randomized run against a transaction-level model.
module tb_ctrl_seq;
    import ctrl_seq_pkg::*;

    localparam int unsigned TMO = 8;
    localparam logic [39:0] RST_VEC = {1'b1, 39'd0};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [OP_W-1:0] op_code = '0;
    logic            flush = 1'b0;
    logic [OP_W-1:0] dec_op;
    logic [CW_W-1:0] dec_cw;
    logic            cw_valid;
    logic            cw_ready = 1'b0;
    logic [CW_W-1:0] cw;
    logic [1:0]      cw_beat;
    logic            cw_last;
    logic            busy;
    logic            err_tmo;
    logic [39:0]     obs;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign dec_cw = ~{19'b0, dec_op};
    assign obs    = {op_ready, dec_op, cw_valid, cw, cw_beat, cw_last, busy, err_tmo};

    ctrl_seq #(.TMO_CYC(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .flush    (flush),
        .dec_op   (dec_op),
        .dec_cw   (dec_cw),
        .cw_valid (cw_valid),
        .cw_ready (cw_ready),
        .cw       (cw),
        .cw_beat  (cw_beat),
        .cw_last  (cw_last),
        .busy     (busy),
        .err_tmo  (err_tmo)
    );

    function automatic logic [CW_W-1:0] exp_cw(input logic [OP_W-1:0] op);
        return ~{19'b0, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", obs, RST_VEC);
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", obs, RST_VEC);
        end
    endtask

    task automatic test_single();
        tick();
        op_code = 7'h18; op_valid = 1'b1; cw_ready = 1'b1;
        @(negedge clk);
        total++;
        if (op_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_ready: got %b want 1", op_ready);
        end
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, op_ready, cw_valid, dec_op} !== {1'b1, 1'b0, 1'b0, 7'h18}) begin
            bad++;
            $display("FAIL single_dec: got %b%b%b %h want 100 18", busy, op_ready, cw_valid, dec_op);
        end
        tick();
        @(negedge clk);
        total++;
        if ({cw_valid, cw, cw_beat, cw_last} !== {1'b1, 26'h3FFFFE7, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL single_beat: got v=%b cw=%h b=%0d l=%b want v=1 cw=3ffffe7 b=0 l=1",
                     cw_valid, cw, cw_beat, cw_last);
        end
        tick();
        @(negedge clk);
        total++;
        if ({op_ready, cw_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL single_done: got %b%b%b want 100", op_ready, cw_valid, busy);
        end
    endtask

    task automatic test_four_beats();
        logic rdy_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int   beat_seq[5] = '{0, 1, 1, 2, 3};
        logic [CW_W-1:0] ecw;
        ecw = exp_cw(7'h63);
        tick();
        op_code = 7'h63; op_valid = 1'b1; cw_ready = 1'b0;
        tick();
        op_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            cw_ready = rdy_seq[i];
            @(negedge clk);
            total++;
            if ({cw_valid, cw, cw_beat, cw_last} !== {1'b1, ecw, 2'(beat_seq[i]), (i == 4)}) begin
                bad++;
                $display("FAIL four_beat[%0d]: got v=%b cw=%h b=%0d l=%b want v=1 cw=%h b=%0d l=%b",
                         i, cw_valid, cw, cw_beat, cw_last, ecw, beat_seq[i], (i == 4));
            end
            tick();
        end
        @(negedge clk);
        total++;
        if ({op_ready, cw_valid, busy} !== 3'b100) begin
            bad++;
            $display("FAIL four_done: got %b%b%b want 100", op_ready, cw_valid, busy);
        end
    endtask

    task automatic test_timeout();
        tick();
        op_code = 7'h45; op_valid = 1'b1; cw_ready = 1'b0;
        tick();
        op_valid = 1'b0;
        tick();
        for (int k = 0; k < int'(TMO); k++) begin
            @(negedge clk);
            total++;
            if ({cw_valid, err_tmo, busy} !== 3'b101) begin
                bad++;
                $display("FAIL tmo_stall[%0d]: got v=%b e=%b busy=%b want 1 0 1", k, cw_valid, err_tmo, busy);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if ({err_tmo, cw_valid, busy, cw_beat, cw_last} !== {1'b1, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL tmo_hit: got e=%b v=%b busy=%b b=%0d l=%b want 1 0 0 0 0",
                     err_tmo, cw_valid, busy, cw_beat, cw_last);
        end
        tick();
        @(negedge clk);
        total++;
        if (err_tmo !== 1'b0) begin
            bad++;
            $display("FAIL tmo_pulse: got %b want 0", err_tmo);
        end
        // Accept landing on the stall cycle that would reach the limit must win.
        op_code = 7'h23; op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        repeat (int'(TMO) - 1) tick();
        cw_ready = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({cw_valid, err_tmo, cw_beat, cw_last} !== {1'b1, 1'b0, 2'd1, 1'b1}) begin
            bad++;
            $display("FAIL tmo_accept_wins: got v=%b e=%b b=%0d l=%b want 1 0 1 1",
                     cw_valid, err_tmo, cw_beat, cw_last);
        end
        tick();
        @(negedge clk);
        total++;
        if ({busy, err_tmo} !== 2'b00) begin
            bad++;
            $display("FAIL tmo_accept_done: got busy=%b e=%b want 0 0", busy, err_tmo);
        end
        cw_ready = 1'b0;
    endtask

    task automatic test_flush();
        tick();
        op_code = 7'h0F; op_valid = 1'b1;
        tick();
        op_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, op_ready} !== 2'b10) begin
            bad++;
            $display("FAIL flush_dec_pre: got busy=%b rdy=%b want 1 0", busy, op_ready);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, cw_valid, err_tmo, op_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL flush_dec: got %b%b%b%b want 0001", busy, cw_valid, err_tmo, op_ready);
        end
        op_code = 7'h4A; op_valid = 1'b1; cw_ready = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        total++;
        if ({cw_valid, cw_beat} !== {1'b1, 2'd1}) begin
            bad++;
            $display("FAIL flush_beat1_pre: got v=%b b=%0d want 1 1", cw_valid, cw_beat);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, cw_valid, err_tmo} !== 3'b000) begin
            bad++;
            $display("FAIL flush_issue: got %b%b%b want 000", busy, cw_valid, err_tmo);
        end
        cw_ready = 1'b0;
    endtask

    task automatic test_flush_idle();
        tick();
        flush = 1'b1; op_valid = 1'b1; op_code = 7'h01; cw_ready = 1'b0;
        @(negedge clk);
        total++;
        if (op_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_ready: got %b want 0", op_ready);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        total++;
        if ({op_ready, busy} !== 2'b10) begin
            bad++;
            $display("FAIL flush_idle_next: got rdy=%b busy=%b want 1 0", op_ready, busy);
        end
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, dec_op} !== {1'b1, 7'h01}) begin
            bad++;
            $display("FAIL flush_idle_accept: got busy=%b op=%h want 1 01", busy, dec_op);
        end
        tick();
        cw_ready = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_drain: got busy=%b want 0", busy);
        end
        cw_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        tick();
        op_code = 7'h7E; op_valid = 1'b1; cw_ready = 1'b0;
        tick();
        op_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        total++;
        if ({cw_valid, busy} !== 2'b11) begin
            bad++;
            $display("FAIL areset_pre: got v=%b busy=%b want 1 1", cw_valid, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL areset_mid: got %h want %h", obs, RST_VEC);
        end
        #1 rst_n = 1'b1;
        tick();
        @(negedge clk);
        total++;
        if ({op_ready, busy, cw_valid} !== 3'b100) begin
            bad++;
            $display("FAIL areset_post: got %b%b%b want 100", op_ready, busy, cw_valid);
        end
    endtask

    // Model tracks the op in flight by age, beats delivered and consecutive stalls.
    task automatic test_random();
        logic            m_busy  = 1'b0;
        logic            m_err   = 1'b0;
        logic [OP_W-1:0] m_op    = '0;
        logic [OP_W-1:0] m_dec   = '0;
        int              m_age   = 0;
        int              m_sent  = 0;
        int              m_stall = 0;
        int              nb;
        int              pct = 60;
        logic            exp_v;
        logic [10:0]     exp_a, got_a;
        logic [28:0]     exp_b, got_b;
        tick();
        op_valid = 1'b0; flush = 1'b0; cw_ready = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < 800; c++) begin
            if (c % 32 == 0) pct = ((c / 32) % 3 == 0) ? 12 : (((c / 32) % 3 == 1) ? 60 : 95);
            op_valid = 1'($urandom_range(0, 1));
            op_code  = 7'($urandom);
            flush    = ($urandom_range(0, 31) == 0);
            cw_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            nb    = int'(m_op[6:5]) + 1;
            exp_v = m_busy && (m_age >= 2);
            got_a = {busy, op_ready, cw_valid, err_tmo, dec_op};
            exp_a = {m_busy, !m_busy && !flush, exp_v, m_err, m_dec};
            total++;
            if (got_a !== exp_a) begin
                bad++;
                $display("FAIL rand_ctrl[%0d]: got %h want %h", c, got_a, exp_a);
            end
            if (exp_v) begin
                got_b = {cw, cw_beat, cw_last};
                exp_b = {exp_cw(m_op), 2'(m_sent), (m_sent == nb - 1)};
                total++;
                if (got_b !== exp_b) begin
                    bad++;
                    $display("FAIL rand_beat[%0d]: got %h want %h", c, got_b, exp_b);
                end
            end
            m_err = 1'b0;
            if (!m_busy) begin
                if (op_valid && !flush) begin
                    m_busy = 1'b1; m_op = op_code; m_dec = op_code;
                    m_age = 1; m_sent = 0; m_stall = 0;
                end
            end else if (flush) begin
                m_busy = 1'b0;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (cw_ready) begin
                m_sent++;
                m_stall = 0;
                if (m_sent == nb) m_busy = 1'b0;
            end else begin
                m_stall++;
                if (m_stall == int'(TMO)) begin
                    m_busy = 1'b0;
                    m_err  = 1'b1;
                end
            end
            tick();
        end
        op_valid = 1'b0; flush = 1'b0; cw_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_four_beats();
        test_timeout();
        test_flush();
        test_flush_idle();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
